// File: rtl/lcd_pkg.sv
// lcd_pkg: shared states, HD44780 instruction constants and timing helpers
package lcd_pkg;
  typedef enum logic [2:0] {PWRUP, INIT, IDLE, WRITE, WAIT, WRAP} state_t;
  localparam logic [7:0] CLR = 8'h01, HOME = 8'h02, ENTRY = 8'h06, DISP_ON = 8'h0C;
  localparam logic [7:0] FSET8 = 8'h38, FSET4 = 8'h28, DDRAM = 8'h80;
  function automatic logic [6:0] row_base(input logic [1:0] r);
    return r == 2'd0 ? 7'h00 : r == 2'd1 ? 7'h40 : r == 2'd2 ? 7'h14 : 7'h54;
  endfunction
  function automatic int us_to_cyc(input int us, input int clk_hz);
    return (longint'(us) * clk_hz / 1000000 < 1) ? 1 : int'(longint'(us) * clk_hz / 1000000);
  endfunction
endpackage

// File: rtl/lcd_bus_writer.sv
// lcd_bus_writer: one panel write with setup/EN/hold timing, split into nibbles on a 4-bit bus
module lcd_bus_writer
  import lcd_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BUS_WIDTH = 8,
  parameter int EN_US     = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 single,
  input  logic                 rs,
  input  logic [7:0]           data,
  output logic                 done,
  output logic                 lcd_rs,
  output logic                 lcd_en,
  output logic [BUS_WIDTH-1:0] lcd_data
);
  localparam int EN_CYC = us_to_cyc(EN_US, CLK_HZ);
  localparam int CW = $clog2(EN_CYC + 1);
  logic busy, lo, one, rs_q;
  logic [1:0] ph;
  logic [CW-1:0] cnt;
  logic [7:0] byte_q;
  logic ph_end;
  assign ph_end = cnt == CW'(EN_CYC - 1);
  // phase 0 = setup, 1 = EN high, 2 = hold; a 4-bit byte repeats the phases for the low nibble
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0; lo <= 1'b0; one <= 1'b0; rs_q <= 1'b0; ph <= 2'd0; cnt <= '0; byte_q <= '0; done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!busy && start) begin
        busy <= 1'b1; ph <= 2'd0; cnt <= '0; lo <= 1'b0; one <= single; rs_q <= rs; byte_q <= data;
      end else if (busy) begin
        cnt <= ph_end ? '0 : cnt + 1'b1;
        if (ph_end && ph != 2'd2) ph <= ph + 2'd1;
        if (ph_end && ph == 2'd2 && BUS_WIDTH == 4 && !lo && !one) begin
          lo <= 1'b1; ph <= 2'd0;
        end else if (ph_end && ph == 2'd2) begin
          busy <= 1'b0; done <= 1'b1;
        end
      end
    end
  end
  assign lcd_rs = rs_q;
  assign lcd_en = busy && ph == 2'd1;
  if (BUS_WIDTH == 4) begin : g_nib
    assign lcd_data = lo ? byte_q[3:0] : byte_q[7:4];
  end else begin : g_byte
    assign lcd_data = byte_q;
  end
endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// lcd_hd44780_ctrl: HD44780 init sequencer, byte handshake and cursor tracking with auto-wrap
module lcd_hd44780_ctrl
  import lcd_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BUS_WIDTH  = 8,
  parameter int ROWS       = 2,
  parameter int COLS       = 16,
  parameter int POWERUP_US = 20000,
  parameter int CMD_US     = 50,
  parameter int CLEAR_US   = 2000,
  parameter int EN_US      = 1,
  parameter int AUTO_WRAP  = 1
) (
  input  logic                 iclk,
  input  logic                 irst,
  input  logic                 i_valid,
  input  logic                 i_rs,
  input  logic [7:0]           i_data,
  output logic                 o_ready,
  output logic                 o_init_done,
  output logic [1:0]           o_row,
  output logic [5:0]           o_col,
  output logic                 LCD_RS,
  output logic                 LCD_RW,
  output logic                 LCD_EN,
  output logic [BUS_WIDTH-1:0] LCD_DATA
);
  localparam int PWR_CYC = us_to_cyc(POWERUP_US, CLK_HZ);
  localparam int C4100 = us_to_cyc(4100, CLK_HZ);
  localparam int C100 = us_to_cyc(100, CLK_HZ);
  localparam int CMD_CYC = us_to_cyc(CMD_US, CLK_HZ);
  localparam int CLR_CYC = us_to_cyc(CLEAR_US, CLK_HZ);
  localparam int WMAX = PWR_CYC > C4100 ? (PWR_CYC > CLR_CYC ? PWR_CYC : CLR_CYC) : (C4100 > CLR_CYC ? C4100 : CLR_CYC);
  localparam int WW = $clog2(WMAX + 1);
  localparam logic [2:0] LAST_IDX = 3'(BUS_WIDTH == 4 ? 7 : 6);
  localparam logic [5:0] COLS6 = 6'(COLS), LAST = 6'(COLS - 1);
  localparam logic [1:0] LROW = 2'(ROWS - 1);
  function automatic logic [7:0] rom_byte(input logic [2:0] i);
    if (BUS_WIDTH == 4)
      return i < 3'd3 ? 8'h30 : i == 3'd3 ? 8'h20 : i == 3'd4 ? (ROWS == 1 ? 8'h20 : FSET4) :
             i == 3'd5 ? DISP_ON : i == 3'd6 ? CLR : ENTRY;
    return i < 3'd3 ? 8'h30 : i == 3'd3 ? (ROWS == 1 ? 8'h30 : FSET8) : i == 3'd4 ? DISP_ON :
           i == 3'd5 ? CLR : ENTRY;
  endfunction
  function automatic int rom_wait(input logic [2:0] i);
    return i == 3'd0 ? C4100 : i == 3'd1 ? C100 : rom_byte(i) == CLR ? CLR_CYC : CMD_CYC;
  endfunction
  state_t state, state_n;
  logic [WW-1:0] wcnt, tgt_m1;
  logic [2:0] idx;
  logic sent, dly, start, done, rs_q, long_w, wrap_q, wait_end, step, accept, long_a, wrap_a;
  logic [7:0] byte_q;
  logic [1:0] row_a;
  logic [5:0] col_a;
  logic [6:0] off;
  assign o_ready = state == IDLE && o_init_done;
  assign accept = o_ready && i_valid;
  assign wait_end = wcnt == tgt_m1;
  assign step = state == INIT && dly && wait_end;
  assign long_a = !i_rs && i_data[7:2] == 6'd0 && i_data[1:0] != 2'd0;
  assign LCD_RW = 1'b0;
  // state register
  always_ff @(posedge iclk) state <= irst ? PWRUP : state_n;
  // next state, writer kick and current wait length
  always_comb begin
    state_n = state;
    start = 1'b0;
    tgt_m1 = state == PWRUP ? WW'(PWR_CYC - 1) : state == INIT ? WW'(rom_wait(idx) - 1) :
             WW'((long_w ? CLR_CYC : CMD_CYC) - 1);
    case (state)
      PWRUP: state_n = wait_end ? INIT : PWRUP;
      INIT: begin
        start = !sent;
        state_n = step && idx == LAST_IDX ? IDLE : INIT;
      end
      IDLE: state_n = accept ? WRITE : IDLE;
      WRITE: begin
        start = !sent;
        state_n = done ? WAIT : WRITE;
      end
      WAIT: state_n = wait_end ? (wrap_q ? WRAP : IDLE) : WAIT;
      WRAP: state_n = WRITE;
      default: state_n = PWRUP;
    endcase
  end
  // cursor position after the byte currently offered on i_data
  always_comb begin
    row_a = o_row;
    col_a = o_col;
    wrap_a = 1'b0;
    off = i_data[6:0];
    if (i_rs) begin
      if (AUTO_WRAP != 0 && o_col == LAST) begin
        col_a = '0;
        row_a = o_row == LROW ? 2'd0 : o_row + 2'd1;
        wrap_a = 1'b1;
      end else if (o_col != COLS6) col_a = o_col + 6'd1;
    end else if (i_data[7]) begin
      row_a = ROWS > 3 && i_data[6:0] >= 7'h54 ? 2'd3 : ROWS > 1 && i_data[6:0] >= 7'h40 ? 2'd1 :
              ROWS > 2 && i_data[6:0] >= 7'h14 ? 2'd2 : 2'd0;
      off = i_data[6:0] - row_base(row_a);
      col_a = off > 7'(COLS - 1) ? LAST : off[5:0];
    end else if (long_a) begin
      row_a = 2'd0;
      col_a = 6'd0;
    end
  end
  // wait counter, init ROM index, captured request and cursor registers
  always_ff @(posedge iclk) begin
    if (irst) begin
      wcnt <= '0; idx <= '0; sent <= 1'b0; dly <= 1'b0; o_init_done <= 1'b0; rs_q <= 1'b0;
      byte_q <= '0; long_w <= 1'b0; wrap_q <= 1'b0; o_row <= '0; o_col <= '0;
    end else begin
      wcnt <= (state != state_n || (state == INIT && (!dly || wait_end))) ? '0 : wcnt + 1'b1;
      sent <= (state != state_n || step) ? 1'b0 : sent | start;
      if (state == INIT && done) dly <= 1'b1;
      if (step) begin
        idx <= idx + 3'd1;
        dly <= 1'b0;
        if (idx == LAST_IDX) o_init_done <= 1'b1;
      end
      if (accept) begin
        rs_q <= i_rs; byte_q <= i_data; long_w <= long_a; wrap_q <= wrap_a; o_row <= row_a; o_col <= col_a;
      end
      if (state == WRAP) begin
        rs_q <= 1'b0; byte_q <= DDRAM | {1'b0, row_base(o_row)}; long_w <= 1'b0; wrap_q <= 1'b0;
      end
    end
  end
  lcd_bus_writer #(.CLK_HZ(CLK_HZ), .BUS_WIDTH(BUS_WIDTH), .EN_US(EN_US)) u_writer (
    .clk(iclk), .rst(irst), .start(start), .single(state == INIT && BUS_WIDTH == 4 && idx < 3'd4),
    .rs(state != INIT && rs_q), .data(state == INIT ? rom_byte(idx) : byte_q),
    .done(done), .lcd_rs(LCD_RS), .lcd_en(LCD_EN), .lcd_data(LCD_DATA)
  );
endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// tb_lcd_hd44780_ctrl: randomized scenarios on 8-bit and 4-bit controllers against a cursor/transfer model
module tb_lcd_hd44780_ctrl;
  localparam int ROWS = 2, COLS = 16, CMD = 50, CLR = 2000, PWR = 100;
  logic clk = 1'b0, rst = 1'b1, valid = 1'b0, valid4 = 1'b0, rs = 1'b0;
  logic [7:0] data = 8'h00;
  logic rdy8, done8, lrs8, lrw8, len8, rdy4, done4, lrs4, lrw4, len4;
  logic [1:0] row8, row4;
  logic [5:0] col8, col4;
  logic [7:0] ld8;
  logic [3:0] ld4;
  int total = 0, bad = 0, mrow = 0, mcol = 0;
  int bases[4] = '{0, 64, 20, 84};
  logic [8:0] q8[$], exp8[$];
  logic [4:0] q4[$];
  logic en8_p = 1'b0, en4_p = 1'b0;

  lcd_hd44780_ctrl #(.CLK_HZ(1_000_000), .BUS_WIDTH(8), .ROWS(ROWS), .COLS(COLS), .POWERUP_US(PWR)) dut8 (
    .iclk(clk), .irst(rst), .i_valid(valid), .i_rs(rs), .i_data(data), .o_ready(rdy8), .o_init_done(done8),
    .o_row(row8), .o_col(col8), .LCD_RS(lrs8), .LCD_RW(lrw8), .LCD_EN(len8), .LCD_DATA(ld8));
  lcd_hd44780_ctrl #(.CLK_HZ(1_000_000), .BUS_WIDTH(4), .ROWS(ROWS), .COLS(COLS), .POWERUP_US(PWR)) dut4 (
    .iclk(clk), .irst(rst), .i_valid(valid4), .i_rs(rs), .i_data(data), .o_ready(rdy4), .o_init_done(done4),
    .o_row(row4), .o_col(col4), .LCD_RS(lrs4), .LCD_RW(lrw4), .LCD_EN(len4), .LCD_DATA(ld4));

  always #5 clk = ~clk;

  // record every EN pulse (RS + bus value) as the panel would latch it
  always @(negedge clk) begin
    if (len8 && !en8_p) q8.push_back({lrs8, ld8});
    if (len4 && !en4_p) q4.push_back({lrs4, ld4});
    en8_p = len8;
    en4_p = len4;
  end

  // expected panel traffic and cursor for one accepted byte
  function automatic void model(input logic r, input logic [7:0] d);
    int a, best;
    exp8.push_back({r, d});
    if (r) begin
      if (mcol < COLS) mcol++;
      if (mcol == COLS) begin
        mcol = 0;
        mrow = (mrow + 1) % ROWS;
        exp8.push_back({1'b0, 8'h80 | 8'(bases[mrow])});
      end
    end else if (d[7]) begin
      a = int'(d[6:0]);
      best = 0;
      for (int k = 0; k < ROWS; k++) if (bases[k] <= a && bases[k] >= bases[best]) best = k;
      mrow = best;
      mcol = a - bases[best];
      if (mcol > COLS - 1) mcol = COLS - 1;
    end else if (d >= 8'd1 && d <= 8'd3) begin
      mrow = 0;
      mcol = 0;
    end
  endfunction

  task automatic send(input logic r, input logic [7:0] d, output int busy, output bit ok);
    int n = 0;
    ok = 1'b0;
    busy = 0;
    while (!rdy8 && n < 5000) begin @(negedge clk); n++; end
    if (!rdy8) return;
    rs = r; data = d; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    n = 0;
    while (!rdy8 && n < 5000) begin @(negedge clk); n++; end
    busy = n;
    ok = rdy8;
    model(r, d);
  endtask

  task automatic test_reset;
    rst = 1'b1; valid = 1'b1; rs = 1'b1; data = 8'h41;
    repeat (3) @(negedge clk);
    total++; if (rdy8 !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0b exp=0", rdy8); end
    total++; if (done8 !== 1'b0) begin bad++; $display("FAIL reset_init_done got=%0b exp=0", done8); end
    total++; if ({len8, lrs8, lrw8, ld8} !== 11'd0) begin bad++; $display("FAIL reset_pins got=%0h exp=0", {len8, lrs8, lrw8, ld8}); end
    total++; if ({row8, col8} !== 8'd0) begin bad++; $display("FAIL reset_cursor got=%0h exp=0", {row8, col8}); end
    total++; if ({len4, ld4, rdy4} !== 6'd0) begin bad++; $display("FAIL reset_4bit got=%0h exp=0", {len4, ld4, rdy4}); end
    q8.delete(); q4.delete(); exp8.delete(); mrow = 0; mcol = 0;
    rst = 1'b0;
  endtask

  // i_valid is left high through init; it must be ignored until ready
  task automatic test_init;
    logic [8:0] e8[7] = '{9'h030, 9'h030, 9'h030, 9'h038, 9'h00C, 9'h001, 9'h006};
    logic [4:0] e4[12] = '{5'h3, 5'h3, 5'h3, 5'h2, 5'h2, 5'h8, 5'h0, 5'hC, 5'h0, 5'h1, 5'h0, 5'h6};
    int n = 0, first = -1;
    while (!(done8 && done4) && n < 20000) begin
      @(negedge clk); n++;
      if (len8 && first < 0) first = n;
      if (done8) valid = 1'b0;
    end
    valid = 1'b0;
    total++; if (!(done8 && done4)) begin bad++; $display("FAIL init_timeout got=%0b%0b exp=11", done8, done4); end
    total++; if (first < PWR || first > PWR + 10) begin bad++; $display("FAIL init_first_en got=%0d exp=%0d..%0d", first, PWR, PWR + 10); end
    total++; if (rdy8 !== 1'b1) begin bad++; $display("FAIL init_ready got=%0b exp=1", rdy8); end
    total++; if (lrw8 !== 1'b0 || lrw4 !== 1'b0) begin bad++; $display("FAIL init_rw got=%0b%0b exp=00", lrw8, lrw4); end
    total++; if (q8.size() != 7) begin bad++; $display("FAIL init8_count got=%0d exp=7", q8.size()); end
    for (int i = 0; i < 7 && i < q8.size(); i++) begin
      total++; if (q8[i] !== e8[i]) begin bad++; $display("FAIL init8_byte%0d got=%0h exp=%0h", i, q8[i], e8[i]); end
    end
    total++; if (q4.size() != 12) begin bad++; $display("FAIL init4_count got=%0d exp=12", q4.size()); end
    for (int i = 0; i < 12 && i < q4.size(); i++) begin
      total++; if (q4[i] !== e4[i]) begin bad++; $display("FAIL init4_nib%0d got=%0h exp=%0h", i, q4[i], e4[i]); end
    end
    q8.delete(); q4.delete();
  endtask

  task automatic test_single_char;
    int n = 0, low = 0;
    while (!rdy8 && n < 5000) begin @(negedge clk); n++; end
    rs = 1'b1; data = 8'h41; valid = 1'b1;
    repeat (3) begin @(negedge clk); if (!rdy8) low++; end
    valid = 1'b0;
    n = 0;
    while (!rdy8 && n < 5000) begin @(negedge clk); n++; low++; end
    model(1'b1, 8'h41);
    total++; if (low < CMD) begin bad++; $display("FAIL char_busy got=%0d exp>=%0d", low, CMD); end
    total++; if (q8.size() != 1) begin bad++; $display("FAIL char_count got=%0d exp=1", q8.size()); end
    total++; if (q8.size() > 0 && q8[0] !== 9'h141) begin bad++; $display("FAIL char_byte got=%0h exp=141", q8[0]); end
    total++; if (col8 !== 6'(mcol) || row8 !== 2'(mrow)) begin bad++; $display("FAIL char_cursor got=%0d,%0d exp=%0d,%0d", row8, col8, mrow, mcol); end
    q8.delete(); exp8.delete();
  endtask

  task automatic test_wrap;
    int busy;
    bit ok;
    send(1'b0, 8'h80, busy, ok);
    total++; if (!ok || row8 !== 2'd0 || col8 !== 6'd0) begin bad++; $display("FAIL wrap_home got=%0b/%0d,%0d exp=1/0,0", ok, row8, col8); end
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < COLS; i++) send(1'b1, 8'($urandom_range(32, 126)), busy, ok);
      total++; if (row8 !== 2'(mrow) || col8 !== 6'(mcol)) begin bad++; $display("FAIL wrap_cursor%0d got=%0d,%0d exp=%0d,%0d", pass, row8, col8, mrow, mcol); end
      total++; if (q8.size() == 0 || q8[q8.size() - 1] !== (pass == 0 ? 9'h0C0 : 9'h080)) begin bad++; $display("FAIL wrap_cmd%0d got=%0h exp=%0h", pass, q8.size() ? q8[q8.size() - 1] : 9'h1FF, pass == 0 ? 9'h0C0 : 9'h080); end
    end
    total++; if (q8.size() != exp8.size()) begin bad++; $display("FAIL wrap_count got=%0d exp=%0d", q8.size(), exp8.size()); end
    for (int i = 0; i < q8.size() && i < exp8.size(); i++) begin
      total++; if (q8[i] !== exp8[i]) begin bad++; $display("FAIL wrap_byte%0d got=%0h exp=%0h", i, q8[i], exp8[i]); end
    end
    q8.delete(); exp8.delete();
  endtask

  task automatic test_clear;
    int busy;
    bit ok;
    for (int i = 0; i < 5; i++) send(1'b1, 8'($urandom_range(32, 126)), busy, ok);
    send(1'b0, 8'h01, busy, ok);
    total++; if (!ok || busy < CLR) begin bad++; $display("FAIL clear_busy got=%0d exp>=%0d", busy, CLR); end
    total++; if (row8 !== 2'd0 || col8 !== 6'd0) begin bad++; $display("FAIL clear_cursor got=%0d,%0d exp=0,0", row8, col8); end
    for (int i = 0; i < COLS; i++) send(1'b1, 8'($urandom_range(32, 126)), busy, ok);
    total++; if (row8 !== 2'd1 || col8 !== 6'd0) begin bad++; $display("FAIL clear_wrap got=%0d,%0d exp=1,0", row8, col8); end
    total++; if (q8.size() != exp8.size()) begin bad++; $display("FAIL clear_count got=%0d exp=%0d", q8.size(), exp8.size()); end
    for (int i = 0; i < q8.size() && i < exp8.size(); i++) begin
      total++; if (q8[i] !== exp8[i]) begin bad++; $display("FAIL clear_byte%0d got=%0h exp=%0h", i, q8[i], exp8[i]); end
    end
    q8.delete(); exp8.delete();
  endtask

  task automatic test_random_mix;
    logic [7:0] other[4] = '{8'h06, 8'h0C, 8'h10, 8'h14};
    int busy, kind;
    bit ok;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 3);
      if (kind < 2) send(1'b1, 8'($urandom_range(32, 126)), busy, ok);
      else if (kind == 2) send(1'b0, 8'h80 | 8'($urandom_range(0, 103)), busy, ok);
      else send(1'b0, other[$urandom_range(0, 3)], busy, ok);
      total++; if (!ok || row8 !== 2'(mrow) || col8 !== 6'(mcol)) begin bad++; $display("FAIL mix_cursor%0d got=%0b/%0d,%0d exp=1/%0d,%0d", i, ok, row8, col8, mrow, mcol); end
    end
    total++; if (q8.size() != exp8.size()) begin bad++; $display("FAIL mix_count got=%0d exp=%0d", q8.size(), exp8.size()); end
    for (int i = 0; i < q8.size() && i < exp8.size(); i++) begin
      total++; if (q8[i] !== exp8[i]) begin bad++; $display("FAIL mix_byte%0d got=%0h exp=%0h", i, q8[i], exp8[i]); end
    end
    q8.delete(); exp8.delete();
  endtask

  task automatic test_reset_mid_write;
    int n = 0;
    while (!rdy8 && n < 5000) begin @(negedge clk); n++; end
    rs = 1'b1; data = 8'h5A; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    n = 0;
    while (!len8 && n < 20) begin @(negedge clk); n++; end
    total++; if (len8 !== 1'b1) begin bad++; $display("FAIL mid_en_seen got=%0b exp=1", len8); end
    rst = 1'b1; valid = 1'b1; rs = 1'b0; data = 8'h01;
    @(negedge clk);
    total++; if (len8 !== 1'b0) begin bad++; $display("FAIL mid_en_drop got=%0b exp=0", len8); end
    total++; if (rdy8 !== 1'b0 || done8 !== 1'b0) begin bad++; $display("FAIL mid_flags got=%0b%0b exp=00", rdy8, done8); end
    total++; if (row8 !== 2'd0 || col8 !== 6'd0) begin bad++; $display("FAIL mid_cursor got=%0d,%0d exp=0,0", row8, col8); end
    @(negedge clk);
    q8.delete(); q4.delete(); exp8.delete(); mrow = 0; mcol = 0;
    rst = 1'b0; valid = 1'b0;
    test_init;
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_init;
    test_single_char;
    test_wrap;
    test_clear;
    test_random_mix;
    test_reset_mid_write;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
